// File: rtl/reset_sequencer_pf.sv
// reset_sequencer_pf: staged release of NUM_DOMAINS fabric resets with PLL lock filter and hold time.
// Define RESET_CAUSE_EN to implement the sticky RST_CAUSE register and CAUSE_CLR.
module reset_sequencer_pf #(
   parameter int NUM_DOMAINS = 3,
   parameter int HOLD_CYCLES = 8,
   parameter int RELEASE_DLY = 4,
   parameter int FILTER_LEN  = 4
) (
   input  logic                   CLK,
   input  logic                   EXT_RST_N,
   input  logic                   PLL_LOCK,
   input  logic                   INIT_DONE,
   input  logic                   FPGA_POR_N,
   input  logic                   BANK_x_VDDI_STATUS,
   input  logic                   BANK_y_VDDI_STATUS,
   input  logic                   SS_BUSY,
   input  logic                   FF_US_RESTORE,
   input  logic                   SW_RST_REQ,
   input  logic                   CAUSE_CLR,
   output logic [NUM_DOMAINS-1:0] FABRIC_RESET_N,
   output logic                   PLL_POWERDOWN_B,
   output logic                   SEQ_DONE,
   output logic [3:0]             RST_CAUSE
);
   localparam int M1 = HOLD_CYCLES > NUM_DOMAINS*RELEASE_DLY ? HOLD_CYCLES : NUM_DOMAINS*RELEASE_DLY;
   localparam int MX = M1 > FILTER_LEN ? M1 : FILTER_LEN;
   localparam int CW = $clog2(MX+1);
   typedef enum logic [1:0] {ST_HOLD, ST_WAIT, ST_REL, ST_RUN} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n, step, fcnt;
   logic [NUM_DOMAINS-1:0] fab, fab_n;
   logic [4:0] s1, s2;
   logic lock_ok, src_bad, blocked;
   assign PLL_POWERDOWN_B = FPGA_POR_N & BANK_x_VDDI_STATUS & BANK_y_VDDI_STATUS;
   assign lock_ok = s2[0] & (fcnt == CW'(FILTER_LEN));
   assign src_bad = !lock_ok | !s2[1] | !s2[2] | SW_RST_REQ;
   assign blocked = s2[3] | s2[4];
   assign FABRIC_RESET_N = fab;
   assign SEQ_DONE = state == ST_RUN;
   // synchroniser bit order: {FF_US_RESTORE, SS_BUSY, FPGA_POR_N, INIT_DONE, PLL_LOCK}; blockers reset high
   always_ff @(posedge CLK) begin
      if (!EXT_RST_N) begin
         s1 <= 5'b11000;
         s2 <= 5'b11000;
         fcnt <= '0;
         state <= ST_HOLD;
         cnt <= '0;
         fab <= '0;
      end else begin
         s1 <= {FF_US_RESTORE, SS_BUSY, FPGA_POR_N, INIT_DONE, PLL_LOCK};
         s2 <= s1;
         fcnt <= !s2[0] ? '0 : lock_ok ? fcnt : fcnt + 1'b1;
         state <= state_n;
         cnt <= cnt_n;
         fab <= fab_n;
      end
   end
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      fab_n = fab;
      step = cnt + 1'b1;
      case (state)
         ST_HOLD: begin
            fab_n = '0;
            cnt_n = (src_bad || cnt == CW'(HOLD_CYCLES-1)) ? '0 : step;
            if (!src_bad && cnt == CW'(HOLD_CYCLES-1)) state_n = ST_WAIT;
         end
         ST_WAIT: if (!blocked) begin
            state_n = NUM_DOMAINS == 1 ? ST_RUN : ST_REL;
            cnt_n = '0;
            fab_n = '0;
            fab_n[0] = 1'b1;
         end
         ST_REL: if (!blocked) begin
            cnt_n = step;
            for (int i = 0; i < NUM_DOMAINS; i++) fab_n[i] = step >= CW'(i*RELEASE_DLY);
            if (step == CW'((NUM_DOMAINS-1)*RELEASE_DLY)) state_n = ST_RUN;
         end
         default: ;
      endcase
      // reassertion overrides any release step taken this cycle
      if (src_bad && state != ST_HOLD) begin
         state_n = ST_HOLD;
         cnt_n = '0;
         fab_n = '0;
      end
   end
`ifdef RESET_CAUSE_EN
   logic [3:0] cause, cause_new;
   assign cause_new = (src_bad && state != ST_HOLD) ? {SW_RST_REQ, !s2[1] | !s2[2], !lock_ok, 1'b0} : 4'b0000;
   always_ff @(posedge CLK) begin
      if (!EXT_RST_N) cause <= 4'b0001;
      else cause <= (CAUSE_CLR ? 4'b0000 : cause) | cause_new;
   end
   assign RST_CAUSE = cause;
`else
   logic unused_cause_clr;
   assign unused_cause_clr = CAUSE_CLR;
   assign RST_CAUSE = 4'b0000;
`endif
endmodule

// File: tb/tb_reset_sequencer_pf.sv
// tb_reset_sequencer_pf: directed and randomized checks of reset_sequencer_pf against a run-length model.
module tb_reset_sequencer_pf;
   localparam int N = 3, H = 8, RD = 4, F = 4;
`ifdef RESET_CAUSE_EN
   localparam bit CAUSE_ON = 1'b1;
`else
   localparam bit CAUSE_ON = 1'b0;
`endif
   logic CLK = 0, EXT_RST_N = 0, PLL_LOCK = 1, INIT_DONE = 1, FPGA_POR_N = 1;
   logic BANK_x_VDDI_STATUS = 1, BANK_y_VDDI_STATUS = 1, SS_BUSY = 0, FF_US_RESTORE = 0;
   logic SW_RST_REQ = 0, CAUSE_CLR = 0;
   logic [N-1:0] FABRIC_RESET_N;
   logic PLL_POWERDOWN_B, SEQ_DONE;
   logic [3:0] RST_CAUSE;
   int checks = 0, errors = 0;
   logic [4:0] h0 = 5'b11000, h1 = 5'b11000;
   int lock_run = 0, run = 0, p = 0;
   logic [3:0] m_cause = 4'b0001;

   reset_sequencer_pf #(.NUM_DOMAINS(N), .HOLD_CYCLES(H), .RELEASE_DLY(RD), .FILTER_LEN(F)) dut (
      .CLK(CLK), .EXT_RST_N(EXT_RST_N), .PLL_LOCK(PLL_LOCK), .INIT_DONE(INIT_DONE),
      .FPGA_POR_N(FPGA_POR_N), .BANK_x_VDDI_STATUS(BANK_x_VDDI_STATUS),
      .BANK_y_VDDI_STATUS(BANK_y_VDDI_STATUS), .SS_BUSY(SS_BUSY), .FF_US_RESTORE(FF_US_RESTORE),
      .SW_RST_REQ(SW_RST_REQ), .CAUSE_CLR(CAUSE_CLR), .FABRIC_RESET_N(FABRIC_RESET_N),
      .PLL_POWERDOWN_B(PLL_POWERDOWN_B), .SEQ_DONE(SEQ_DONE), .RST_CAUSE(RST_CAUSE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // run = consecutive clean edges (capped at H); p = clean unblocked edges taken after the hold window
   task automatic model_edge();
      logic [4:0] s;
      logic lock_ok, bad, blk, was_hold;
      logic [3:0] newc;
      if (!EXT_RST_N) begin
         h0 = 5'b11000; h1 = 5'b11000; lock_run = 0; run = 0; p = 0; m_cause = 4'b0001;
      end else begin
         s = h1;
         lock_ok = s[0] && lock_run >= F;
         bad = !lock_ok || !s[1] || !s[2] || SW_RST_REQ;
         blk = s[3] || s[4];
         was_hold = run < H;
         newc = (bad && !was_hold) ? {SW_RST_REQ, !s[1] || !s[2], !lock_ok, 1'b0} : 4'b0000;
         m_cause = CAUSE_CLR ? newc : (m_cause | newc);
         lock_run = s[0] ? lock_run + 1 : 0;
         if (bad) begin
            run = 0; p = 0;
         end else begin
            if (!was_hold && !blk) p++;
            if (run < H) run++;
         end
         h1 = h0;
         h0 = {FF_US_RESTORE, SS_BUSY, FPGA_POR_N, INIT_DONE, PLL_LOCK};
      end
   endtask

   function automatic int exp_k();
      int k;
      k = p == 0 ? 0 : (p - 1) / RD + 1;
      return k > N ? N : k;
   endfunction

   task automatic tick();
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
      chk("fabric_reset_n", 32'(FABRIC_RESET_N), 32'((1 << exp_k()) - 1));
      chk("seq_done", 32'(SEQ_DONE), 32'(exp_k() == N));
      chk("rst_cause", 32'(RST_CAUSE), 32'(CAUSE_ON ? m_cause : 4'b0000));
      chk("pll_powerdown_b", 32'(PLL_POWERDOWN_B), 32'(FPGA_POR_N & BANK_x_VDDI_STATUS & BANK_y_VDDI_STATUS));
   endtask

   initial begin
      repeat (5) tick();
      chk("reset_fabric", 32'(FABRIC_RESET_N), 32'h0);
      chk("reset_cause", 32'(RST_CAUSE), 32'(CAUSE_ON ? 4'b0001 : 4'b0000));
      EXT_RST_N = 1;
      repeat (14) tick();
      chk("powerup_hold", 32'(FABRIC_RESET_N), 32'b000);
      tick();
      chk("powerup_d0", 32'(FABRIC_RESET_N), 32'b001);
      repeat (4) tick();
      chk("powerup_d1", 32'(FABRIC_RESET_N), 32'b011);
      repeat (4) tick();
      chk("powerup_d2", 32'(FABRIC_RESET_N), 32'b111);
      chk("powerup_done", 32'(SEQ_DONE), 32'h1);
      PLL_LOCK = 0;
      repeat (2) tick();
      PLL_LOCK = 1;
      tick();
      chk("lockloss_assert", 32'(FABRIC_RESET_N), 32'b000);
      chk("lockloss_cause", 32'(RST_CAUSE[1]), 32'(CAUSE_ON));
      repeat (40) tick();
      chk("lockloss_recover", 32'(FABRIC_RESET_N), 32'b111);
      PLL_LOCK = 0;
      repeat (12) tick();
      PLL_LOCK = 1;
      repeat (3) tick();
      PLL_LOCK = 0;
      repeat (12) tick();
      chk("glitch_no_release", 32'(FABRIC_RESET_N), 32'b000);
      PLL_LOCK = 1;
      repeat (14) tick();
      chk("lock_hold", 32'(FABRIC_RESET_N), 32'b000);
      tick();
      chk("lock_release", 32'(FABRIC_RESET_N), 32'b001);
      repeat (8) tick();
      chk("lock_run", 32'(FABRIC_RESET_N), 32'b111);
      SS_BUSY = 1;
      SW_RST_REQ = 1;
      tick();
      SW_RST_REQ = 0;
      repeat (25) tick();
      chk("busy_blocks", 32'(FABRIC_RESET_N), 32'b000);
      SS_BUSY = 0;
      repeat (3) tick();
      chk("busy_clear_d0", 32'(FABRIC_RESET_N), 32'b001);
      SS_BUSY = 1;
      repeat (10) tick();
      chk("busy_freeze", 32'(FABRIC_RESET_N), 32'b001);
      SS_BUSY = 0;
      repeat (8) tick();
      chk("busy_resume", 32'(FABRIC_RESET_N), 32'b111);
      SW_RST_REQ = 1;
      CAUSE_CLR = 1;
      tick();
      SW_RST_REQ = 0;
      CAUSE_CLR = 0;
      chk("sw_assert", 32'(FABRIC_RESET_N), 32'b000);
      chk("sw_clr_cause", 32'(RST_CAUSE), 32'(CAUSE_ON ? 4'b1000 : 4'b0000));
      CAUSE_CLR = 1;
      tick();
      CAUSE_CLR = 0;
      chk("cause_clear", 32'(RST_CAUSE), 32'h0);
      FPGA_POR_N = 0;
      #1 chk("pd_por", 32'(PLL_POWERDOWN_B), 32'h0);
      FPGA_POR_N = 1;
      BANK_y_VDDI_STATUS = 0;
      #1 chk("pd_bank_y", 32'(PLL_POWERDOWN_B), 32'h0);
      BANK_y_VDDI_STATUS = 1;
      #1 chk("pd_all_good", 32'(PLL_POWERDOWN_B), 32'h1);
      for (int i = 0; i < 600; i++) begin
         PLL_LOCK = PLL_LOCK ? ($urandom_range(0, 59) != 0) : ($urandom_range(0, 3) == 0);
         INIT_DONE = INIT_DONE ? ($urandom_range(0, 79) != 0) : ($urandom_range(0, 2) == 0);
         FPGA_POR_N = FPGA_POR_N ? ($urandom_range(0, 99) != 0) : ($urandom_range(0, 2) == 0);
         SS_BUSY = SS_BUSY ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 39) == 0);
         FF_US_RESTORE = FF_US_RESTORE ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 59) == 0);
         BANK_x_VDDI_STATUS = $urandom_range(0, 19) != 0;
         BANK_y_VDDI_STATUS = $urandom_range(0, 19) != 0;
         SW_RST_REQ = $urandom_range(0, 119) == 0;
         CAUSE_CLR = $urandom_range(0, 29) == 0;
         EXT_RST_N = $urandom_range(0, 299) != 0;
         tick();
      end
      {PLL_LOCK, INIT_DONE, FPGA_POR_N, BANK_x_VDDI_STATUS, BANK_y_VDDI_STATUS, EXT_RST_N} = '1;
      {SS_BUSY, FF_US_RESTORE, SW_RST_REQ, CAUSE_CLR} = '0;
      repeat (40) tick();
      chk("final_run", 32'(FABRIC_RESET_N), 32'b111);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
